sprite_compositor: RTL and testbench

- Parametrised N-layer sprite compositor for the VGA path. Sits between the VGA timing generator and the 9-bit RGB pins, and replaces the fixed frog/car colour generator.
- Each layer has its own position, enable and horizontal mirror. Layers are composited over a supplied background with index priority and colour-key transparency.
- Sprite ROM read latency is absorbed by a matched pipeline.
- Sprite 0 (player) vs. any other sprite pixel-exact collisions are accumulated per frame and reported at the start of vertical blank.

---
 rtl/sprite_compositor.sv | 141 ++++++++++++++
 tb/tb_sprite_compositor.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: index-priority, colour-key blend over background, player collision log.
// Latency ROM_LAT+2 clocks from (h_count, v_count) to rgb; sprite ROM addresses leave after 1 clock.
// No backpressure: one pixel per clock, never stalls; collision results update once per frame.
module sprite_compositor #(
  parameter int         NUM_SPRITES = 4,
  parameter int         SPR_W       = 32,
  parameter int         SPR_H       = 32,
  parameter int         ADDR_W      = 10,
  parameter int         ROM_LAT     = 1,
  parameter int         H_DISPLAY   = 640,
  parameter int         V_DISPLAY   = 480,
  parameter logic [8:0] TRANSPARENT = 9'h000
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [9:0]                    h_count,
  input  logic [9:0]                    v_count,
  input  logic [8:0]                    bg_rgb,
  input  logic [10*NUM_SPRITES-1:0]     spr_x,
  input  logic [10*NUM_SPRITES-1:0]     spr_y,
  input  logic [NUM_SPRITES-1:0]        spr_en,
  input  logic [NUM_SPRITES-1:0]        spr_mirror,
  output logic [ADDR_W*NUM_SPRITES-1:0] spr_addr,
  input  logic [9*NUM_SPRITES-1:0]      spr_data,
  output logic [8:0]                    rgb,
  output logic                          collision,
  output logic [NUM_SPRITES-2:0]        collision_mask,
  output logic                          frame_done
);

  // One pipeline word: {hit vector, active, background, h, v}
  localparam int PW = NUM_SPRITES + 1 + 9 + 10 + 10;

  logic [NUM_SPRITES-1:0]        hit_a;
  logic                          active_a;
  logic [ADDR_W*NUM_SPRITES-1:0] spr_addr_d, spr_addr_q;
  logic [ROM_LAT:0][PW-1:0]      pipe_d, pipe_q;

  logic [NUM_SPRITES-1:0]        hit_b;
  logic                          active_b;
  logic [8:0]                    bg_b;
  logic [9:0]                    h_b, v_b;
  logic [NUM_SPRITES-1:0]        opaque_b;
  logic                          frame_end_b;

  logic [8:0]                    rgb_d, rgb_q;
  logic [NUM_SPRITES-2:0]        acc_d, acc_q;
  logic [NUM_SPRITES-2:0]        mask_d, mask_q;
  logic                          collision_d, collision_q;
  logic                          frame_done_d, frame_done_q;

  // Stage A: per-layer bounding-box hit and ROM address; 11-bit sums so edges clip without wrap
  always_comb begin
    logic [9:0] x_i;
    logic [9:0] y_i;
    logic [9:0] col;
    logic [9:0] row;
    x_i        = '0;
    y_i        = '0;
    col        = '0;
    row        = '0;
    hit_a      = '0;
    spr_addr_d = '0;
    active_a   = ({1'b0, h_count} < 11'(H_DISPLAY)) && ({1'b0, v_count} < 11'(V_DISPLAY));
    for (int i = 0; i < NUM_SPRITES; i++) begin
      x_i = spr_x[10*i +: 10];
      y_i = spr_y[10*i +: 10];
      hit_a[i] = spr_en[i] && active_a
              && ({1'b0, h_count} >= {1'b0, x_i}) && ({1'b0, h_count} < {1'b0, x_i} + 11'(SPR_W))
              && ({1'b0, v_count} >= {1'b0, y_i}) && ({1'b0, v_count} < {1'b0, y_i} + 11'(SPR_H));
      col = h_count - x_i;
      if (spr_mirror[i]) col = 10'(SPR_W - 1) - col;
      row = v_count - y_i;
      if (hit_a[i])
        spr_addr_d[ADDR_W*i +: ADDR_W] = ADDR_W'(20'(row) * 20'(SPR_W) + 20'(col));
    end
  end

  // Delay line: slot 0 is the stage-A register, slot ROM_LAT lines up with spr_data
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {hit_a, active_a, bg_rgb, h_count, v_count};
    for (int s = 1; s <= ROM_LAT; s++) pipe_d[s] = pipe_q[s-1];
  end

  assign {hit_b, active_b, bg_b, h_b, v_b} = pipe_q[ROM_LAT];

  // Stage B: lowest-index opaque layer wins; collisions accumulate until the first vblank coordinate
  always_comb begin
    logic [8:0] pix;
    pix          = bg_b;
    opaque_b     = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      opaque_b[i] = hit_b[i] && (spr_data[9*i +: 9] != TRANSPARENT);
      if (opaque_b[i]) pix = spr_data[9*i +: 9];
    end
    rgb_d        = active_b ? pix : 9'h000;
    frame_end_b  = (h_b == 10'd0) && ({1'b0, v_b} == 11'(V_DISPLAY));
    acc_d        = acc_q;
    mask_d       = mask_q;
    collision_d  = collision_q;
    frame_done_d = 1'b0;
    for (int k = 1; k < NUM_SPRITES; k++)
      if (opaque_b[0] && opaque_b[k]) acc_d[k-1] = 1'b1;
    // The vblank coordinate is inactive, so no new hit can land in the cycle we clear
    if (frame_end_b) begin
      collision_d  = |acc_q;
      mask_d       = acc_q;
      acc_d        = '0;
      frame_done_d = 1'b1;
    end
  end

  // All state registers; reset clears pipeline so the first outputs after release are black
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      spr_addr_q   <= '0;
      pipe_q       <= '0;
      rgb_q        <= '0;
      acc_q        <= '0;
      mask_q       <= '0;
      collision_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      spr_addr_q   <= spr_addr_d;
      pipe_q       <= pipe_d;
      rgb_q        <= rgb_d;
      acc_q        <= acc_d;
      mask_q       <= mask_d;
      collision_q  <= collision_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign spr_addr       = spr_addr_q;
  assign rgb            = rgb_q;
  assign collision      = collision_q;
  assign collision_mask = mask_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: random and directed pixels against a pixel-rule reference model.
// Expected outputs are queued per issued coordinate and popped by a monitor every clock.
// The DUT never stalls, so the monitor pops exactly one entry per cycle once the pipeline is primed.
module tb_sprite_compositor;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int H   = 32;
  localparam int AW  = 10;
  localparam int RL  = 1;
  localparam int HD  = 640;
  localparam int VD  = 480;
  localparam int LAT = RL + 2;
  localparam logic [8:0] TR = 9'h000;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [9:0]    h_count, v_count;
  logic [8:0]    bg_rgb;
  logic [10*N-1:0] spr_x, spr_y;
  logic [N-1:0]  spr_en, spr_mirror;
  logic [AW*N-1:0] spr_addr;
  logic [9*N-1:0]  spr_data;
  logic [8:0]    rgb;
  logic          collision;
  logic [N-2:0]  collision_mask;
  logic          frame_done;

  always #5 CLK = ~CLK;

  sprite_compositor #(
    .NUM_SPRITES(N), .SPR_W(W), .SPR_H(H), .ADDR_W(AW), .ROM_LAT(RL),
    .H_DISPLAY(HD), .V_DISPLAY(VD), .TRANSPARENT(TR)
  ) dut (
    .CLK(CLK), .RST(RST), .h_count(h_count), .v_count(v_count), .bg_rgb(bg_rgb),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_mirror(spr_mirror),
    .spr_addr(spr_addr), .spr_data(spr_data), .rgb(rgb), .collision(collision),
    .collision_mask(collision_mask), .frame_done(frame_done)
  );

  // Sprite ROMs with RL clocks of read latency
  logic [8:0]     rom [N][1024];
  logic [9*N-1:0] rom_pipe [RL];
  always @(posedge CLK) begin
    for (int s = 0; s < N; s++) rom_pipe[0][9*s +: 9] <= rom[s][spr_addr[AW*s +: AW]];
    for (int j = 1; j < RL; j++) rom_pipe[j] <= rom_pipe[j-1];
  end
  assign spr_data = rom_pipe[RL-1];

  // Layer settings as seen by software
  int sx [N];
  int sy [N];
  bit sen [N];
  bit smir [N];

  typedef struct {
    logic [8:0]   rgb;
    logic         fd;
    logic         coll;
    logic [N-2:0] mask;
  } exp_t;
  exp_t exp_q [$];

  logic [N-2:0] m_acc, m_mask;
  logic         m_coll;
  bit           mon_en = 1'b0;
  int           n_chk  = 0;
  int           n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      spr_x[10*i +: 10] = 10'(sx[i]);
      spr_y[10*i +: 10] = 10'(sy[i]);
      spr_en[i]         = sen[i];
      spr_mirror[i]     = smir[i];
    end
  endtask

  // Reference: evaluate the pixel rules directly for one coordinate and queue the result
  task automatic model_push(input int h, input int v, input logic [8:0] bg);
    exp_t       e;
    bit         act;
    bit         found;
    bit [N-1:0] opq;
    logic [8:0] dat [N];
    int         c, a;
    act = (h < HD) && (v < VD);
    opq = '0;
    for (int i = 0; i < N; i++) begin
      dat[i] = 9'h000;
      if (sen[i] && act && h >= sx[i] && h < sx[i] + W && v >= sy[i] && v < sy[i] + H) begin
        c = h - sx[i];
        if (smir[i]) c = W - 1 - c;
        a = (v - sy[i]) * W + c;
        dat[i] = rom[i][a];
        opq[i] = (rom[i][a] != TR);
      end
    end
    e.rgb = act ? bg : 9'h000;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      if (act && !found && opq[i]) begin
        e.rgb = dat[i];
        found = 1'b1;
      end
    if (opq[0])
      for (int k = 1; k < N; k++)
        if (opq[k]) m_acc[k-1] = 1'b1;
    e.fd = 1'b0;
    if (h == 0 && v == VD) begin
      m_coll = |m_acc;
      m_mask = m_acc;
      m_acc  = '0;
      e.fd   = 1'b1;
    end
    e.coll = m_coll;
    e.mask = m_mask;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int h, input int v, input logic [8:0] bg);
    @(posedge CLK); #1;
    h_count = 10'(h);
    v_count = 10'(v);
    bg_rgb  = bg;
    pack();
    model_push(h, v, bg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(700, 500, 9'h0AA);
  endtask

  task automatic do_reset();
    exp_t z;
    mon_en = 1'b0;
    RST    = 1'b1;
    #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_spr_addr", spr_addr, 0);
    chk("rst_collision", collision, 0);
    chk("rst_collision_mask", collision_mask, 0);
    chk("rst_frame_done", frame_done, 0);
    repeat (2) @(posedge CLK);
    #1;
    exp_q.delete();
    m_acc = '0; m_mask = '0; m_coll = 1'b0;
    h_count = 10'd700; v_count = 10'd500; bg_rgb = 9'h0AA;
    pack();
    RST = 1'b0;
    z.rgb = 9'h000; z.fd = 1'b0; z.coll = 1'b0; z.mask = '0;
    for (int i = 0; i < LAT; i++) exp_q.push_back(z);
    model_push(700, 500, 9'h0AA);
    mon_en = 1'b1;
  endtask

  task automatic fill_rom(input int s, input int pct_tr);
    for (int a = 0; a < 1024; a++)
      rom[s][a] = ($urandom_range(99) < pct_tr) ? TR : 9'($urandom_range(511, 1));
  endtask

  // Monitor: one expected entry per clock, compared away from the active edge
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rgb", rgb, e.rgb);
        chk("frame_done", frame_done, e.fd);
        chk("collision", collision, e.coll);
        chk("collision_mask", collision_mask, e.mask);
      end
    end
  end

  initial begin
    int s, h, v;
    for (int i = 0; i < N; i++) begin
      sx[i] = 0; sy[i] = 0; sen[i] = 0; smir[i] = 0;
      fill_rom(i, 25);
    end
    h_count = 10'd700; v_count = 10'd500; bg_rgb = 9'h0AA;
    pack();
    m_acc = '0; m_mask = '0; m_coll = 1'b0;
    #2;
    do_reset();

    // Background only, plus the inactive right edge
    drive(100, 100, 9'h1FF);
    drive(HD, 100, 9'h1FF);
    drive(639, 479, 9'h123);
    idle(LAT);

    // ROM addressing, plain and mirrored
    sx[1] = 200; sy[1] = 50; sen[1] = 1; smir[1] = 0;
    drive(205, 53, 9'h000);
    drive(700, 500, 9'h0AA);
    chk("spr_addr_plain", spr_addr[AW +: AW], 101);
    smir[1] = 1;
    drive(205, 53, 9'h000);
    drive(700, 500, 9'h0AA);
    chk("spr_addr_mirror", spr_addr[AW +: AW], 122);
    sen[1] = 0; smir[1] = 0;
    idle(LAT + 1);

    // Priority and transparency between layers 0 and 2
    sx[0] = 300; sy[0] = 300; sen[0] = 1;
    sx[2] = 300; sy[2] = 300; sen[2] = 1;
    rom[0][0] = 9'h007; rom[2][0] = 9'h1C0;
    drive(300, 300, 9'h0AA);
    idle(LAT + 1);
    rom[0][0] = TR;
    drive(300, 300, 9'h0AA);
    idle(LAT + 1);
    rom[2][0] = TR;
    drive(300, 300, 9'h0AA);
    drive(0, VD, 9'h0AA);
    idle(LAT + 1);
    sen[0] = 0; sen[2] = 0;

    // Edge clipping, right and bottom
    for (int a = 0; a < 1024; a++) rom[1][a] = 9'(a) | 9'h001;
    sx[1] = 630; sy[1] = 100; sen[1] = 1;
    for (int x = 620; x < 640; x++) drive(x, 110, 9'h055);
    for (int x = 0; x < 22; x++) drive(x, 110, 9'h055);
    sx[1] = 100; sy[1] = 470;
    for (int y = 465; y < 480; y++) drive(105, y, 9'h033);
    for (int y = 0; y < 6; y++) drive(105, y, 9'h033);
    sen[1] = 0;
    idle(LAT + 1);

    // Single-pixel collision of layer 0 with layer 3, then a clean frame
    fill_rom(0, 0); fill_rom(3, 0);
    sx[0] = 50; sy[0] = 50; sen[0] = 1;
    sx[3] = 81; sy[3] = 81; sen[3] = 1;
    drive(0, VD, 9'h000);
    for (int x = 75; x < 91; x++) drive(x, 80, 9'h011);
    for (int x = 75; x < 91; x++) drive(x, 81, 9'h011);
    drive(0, VD, 9'h000);
    idle(LAT + 1);
    sx[3] = 200;
    for (int x = 75; x < 91; x++) drive(x, 81, 9'h011);
    drive(0, VD, 9'h000);
    idle(LAT + 1);

    // Randomised layers and coordinates
    for (int i = 0; i < N; i++) fill_rom(i, 25);
    idle(1);
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 40 == 0)
        for (int i = 0; i < N; i++) begin
          sx[i]   = $urandom_range(660);
          sy[i]   = $urandom_range(500);
          sen[i]  = 1'($urandom_range(3) != 0);
          smir[i] = 1'($urandom_range(1));
        end
      if ($urandom_range(99) < 4) begin
        h = 0; v = VD;
      end else if ($urandom_range(99) < 80) begin
        s = $urandom_range(N - 1);
        h = sx[s] + $urandom_range(W + 8) - 4;
        v = sy[s] + $urandom_range(H + 8) - 4;
      end else begin
        h = $urandom_range(700);
        v = $urandom_range(520);
      end
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      if (h > 1023) h = 1023;
      if (v > 1023) v = 1023;
      drive(h, v, 9'($urandom_range(511)));
    end
    idle(LAT + 1);

    // Reset in the middle of a frame while a collision is being reported
    fill_rom(0, 0); fill_rom(3, 0);
    for (int i = 0; i < N; i++) begin sen[i] = 0; smir[i] = 0; end
    sx[0] = 50; sy[0] = 50; sen[0] = 1;
    sx[3] = 81; sy[3] = 81; sen[3] = 1;
    idle(LAT + 1);
    drive(81, 81, 9'h000);
    drive(0, VD, 9'h000);
    idle(LAT + 1);
    drive(320, 240, 9'h0F0);
    do_reset();
    sx[3] = 200;
    for (int x = 78; x < 86; x++) drive(x, 81, 9'h022);
    drive(0, VD, 9'h000);
    idle(LAT + 2);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
